pcalc_unit_param: RTL and testbench
===================================

// Module: pcalc_unit_param
// PURPOSE
//  Parametrised intersection-point calculator: pos = org + t*dir per axis, in signed fixed point.
//  Sits between the ray-store stage and the shader.
//  Fixed-latency math pipeline plus a rayID/triID/hit sideband pipe feeding an in-order output FIFO.
//  Credit admission guarantees the pipe never overflows the FIFO.
//  Adds over the previous unit: hit/miss pass-through, selectable wrap/saturate arithmetic,
//  generic widths, depth and latency.
// PARAMETERS
//  W          16  data width of t, org and dir components (signed, two's complement)
//  FRAC        8  fractional bits of t (t*dir is shifted right arithmetically by FRAC)
//  ID_W        8  rayID width
//  TRI_W      16  triID width
//  MATH_LAT    4  math pipeline stages, >=1; pipe never stalls internally
//  FIFO_DEPTH  8  output FIFO entries, >=MATH_LAT+1 recommended for full throughput
//  SAT         0  0: per-axis results wrap mod 2^W; 1: saturate to [-2^(W-1), 2^(W-1)-1]
// PORTS
//  clk        in   1        clock
//  rst        in   1        asynchronous reset, active-low
//  in_valid   in   1        upstream entry valid
//  in_stall   out  1        upstream must hold entry
//  in_rayID   in   ID_W     ray identifier
//  in_triID   in   TRI_W    triangle identifier
//  in_hit     in   1        1 = hit (compute pos), 0 = miss (pos forced 0)
//  in_t       in   W        intersection distance, FRAC fractional bits
//  in_org     in   3*W      ray origin {z,y,x}, x in [W-1:0]
//  in_dir     in   3*W      ray direction {z,y,x}
//  out_valid  out  1        output FIFO non-empty
//  out_stall  in   1        downstream stall
//  out_rayID  out  ID_W     FIFO head rayID
//  out_triID  out  TRI_W    FIFO head triID
//  out_hit    out  1        FIFO head hit flag
//  out_pos    out  3*W      FIFO head position {z,y,x}
//  inflight   out  $clog2(FIFO_DEPTH+1)  entries in math pipe plus FIFO
// BEHAVIOUR
//  Reset (rst=0, async):
//   - All pipe valid bits, FIFO pointers and counts cleared.
//   - out_valid=0, in_stall=0, inflight=0; data outputs 0.
//   - Reset mid-operation discards every in-flight and buffered entry.
//  Admission:
//   - accept = in_valid & ~in_stall.
//   - in_stall = (inflight >= FIFO_DEPTH), computed from registered state only.
//   - A same-cycle FIFO pop does not free a credit until the next cycle.
//  Pipe:
//   - An accepted entry enters stage 1 and leaves stage MATH_LAT exactly MATH_LAT cycles later.
//   - On leaving, it is written to the FIFO unconditionally; overflow is impossible by credit.
//   - Sideband travels in lock-step with the math.
//   - Bubbles propagate as valid=0.
//  Output:
//   - out_valid = ~empty; out_* show the FIFO head.
//   - Pop when out_valid & ~out_stall.
//   - Data must stay stable while out_valid & out_stall.
//   - Min latency accept->out_valid = MATH_LAT+1 cycles.
//   - Strict in-order delivery, misses included.
//  inflight (registered):
//   - +1 on accept, -1 on pop, unchanged when both occur or neither occurs.
//  Arithmetic, per axis:
//   - p = signed(t)*signed(dir): 2W bits, exact.
//   - s = p >>> FRAC.
//   - r = s + sign-extended org, kept at 2W bits.
//   - SAT=0: pos = r[W-1:0].
//   - SAT=1: pos is r clamped to the W-bit signed range.
//   - Miss (in_hit=0): pos = 0 regardless of t, org and dir; rayID, triID and hit pass unchanged.
//  Throughput: 1 entry/cycle sustained when out_stall=0 and FIFO_DEPTH >= MATH_LAT+1.
// TESTING
//  W=16,FRAC=8,SAT=0:
//   - Stimulus: t=0x0200, dir={0x0080,0xFF00,0x0100}, org={0,0,0x0100}, rayID=5, triID=9.
//   - Response: after 5 cycles out_pos={0x0100,0xFE00,0x0300}, rayID=5, triID=9, hit=1.
//  SAT=1:
//   - Stimulus: t=0x7F00, dir.x=0x7F00, org.x=0x7000.
//   - Response: pos.x=0x7FFF.
//   - Stimulus: t=0x7F00, dir.x=0x8100 (-127.0).
//   - Response: pos.x=0x8000.
//  Miss pass-through:
//   - Stimulus: hit=0, t=0x0200, dir.x=0x0100, org.x=0x0100.
//   - Response: pos=0, hit=0, IDs preserved.
//   - Stimulus: mixed hit/miss burst of 20.
//   - Response: output order equals input order.
//  Backpressure (FIFO_DEPTH=8, MATH_LAT=4):
//   - Stimulus: out_stall=1 while streaming.
//   - Response: exactly 8 accepts, then in_stall=1 and inflight=8; no loss after release.
//   - Stimulus: release with one pop.
//   - Response: in_stall drops the cycle after that pop.
//  Simultaneous accept+pop at inflight=8: count holds.
//  Full-rate:
//   - Stimulus: 100 back-to-back entries with out_stall=0.
//   - Response: in_stall never asserts; out_valid continuous from cycle 5.
//  Async reset:
//   - Stimulus: rst low mid-burst with 6 in flight.
//   - Response: out_valid=0, inflight=0 immediately; next entry after reset emerges with correct data.

Source files
------------

// File: rtl/pcalc_unit_param.sv
// pcalc_unit_param: intersection point pos = org + t*dir per axis, signed fixed point,
//   with a rayID/triID/hit sideband carried alongside the math into an in-order output FIFO.
// Latency: MATH_LAT cycles through the math pipe plus one cycle into the FIFO (MATH_LAT+1 minimum).
// Backpressure: credit based; in_stall rises once pipe plus FIFO hold FIFO_DEPTH entries.
//   A downstream stall only fills the FIFO and never stalls the math pipe.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid / in_stall      upstream handshake; accept = in_valid & ~in_stall
//   in_rayID, in_triID       sideband identifiers, passed through unchanged
//   in_hit                   1 = compute position, 0 = miss (position forced to zero)
//   in_t, in_org, in_dir     distance (FRAC fractional bits), origin {z,y,x} and direction {z,y,x}
//   out_valid / out_stall    downstream handshake; pop = out_valid & ~out_stall
//   out_rayID .. out_pos     FIFO head; all zero while the FIFO is empty
//   inflight                 entries held in the math pipe plus the FIFO

// Generic FIFO used for the output buffer.
// Latency: one cycle from write to rd_vld; the head is read combinationally.
// Backpressure: none on the write side; the caller guarantees it never writes when full.
module pcalc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             rd_fire;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign rd_fire = rd_vld & rd_rdy;
  assign rd_vld  = (count != '0);
  // Gating the head keeps the data outputs at zero whenever nothing is buffered.
  assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_fire) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr_vld, rd_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

endmodule

module pcalc_unit_param #(
  parameter int W          = 16,
  parameter int FRAC       = 8,
  parameter int ID_W       = 8,
  parameter int TRI_W      = 16,
  parameter int MATH_LAT   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int SAT        = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_stall,
  input  logic [ID_W-1:0]                  in_rayID,
  input  logic [TRI_W-1:0]                 in_triID,
  input  logic                             in_hit,
  input  logic [W-1:0]                     in_t,
  input  logic [3*W-1:0]                   in_org,
  input  logic [3*W-1:0]                   in_dir,
  output logic                             out_valid,
  input  logic                             out_stall,
  output logic [ID_W-1:0]                  out_rayID,
  output logic [TRI_W-1:0]                 out_triID,
  output logic                             out_hit,
  output logic [3*W-1:0]                   out_pos,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  inflight
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // Clamp bounds for the 2W-bit intermediate sum.
  localparam logic signed [2*W-1:0] R_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] R_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  // Pipe stage payload: products are formed on entry, the shift/add/clamp happens on exit.
  typedef struct packed {
    logic             hit;
    logic [ID_W-1:0]  ray_id;
    logic [TRI_W-1:0] tri_id;
    logic [3*W-1:0]   org;
    logic [6*W-1:0]   prod;
  } stg_t;

  // FIFO entry as presented downstream.
  typedef struct packed {
    logic [ID_W-1:0]  ray_id;
    logic [TRI_W-1:0] tri_id;
    logic             hit;
    logic [3*W-1:0]   pos;
  } res_t;

  logic                accept;
  logic                pop;
  logic [MATH_LAT-1:0] stg_vld;
  stg_t                stg_dat [MATH_LAT];
  stg_t                in_stg;
  stg_t                last_stg;
  res_t                wr_res;
  res_t                rd_res;
  logic                fifo_vld;

  // Exact signed W x W product, both operands sign-extended to 2W first.
  function automatic logic [2*W-1:0] mul_ax(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] ae;
    logic signed [2*W-1:0] be;
    ae = {{W{a[W-1]}}, a};
    be = {{W{b[W-1]}}, b};
    return ae * be;
  endfunction

  // Scale back to the org format (arithmetic shift floors toward -inf), add org,
  // then wrap or clamp to W bits.
  function automatic logic [W-1:0] finish_ax(input logic [2*W-1:0] p, input logic [W-1:0] o);
    logic signed [2*W-1:0] s;
    logic signed [2*W-1:0] r;
    s = $signed(p) >>> FRAC;
    r = s + $signed({{W{o[W-1]}}, o});
    if (SAT == 0) begin
      return r[W-1:0];
    end else if (r > R_MAX) begin
      return {1'b0, {(W-1){1'b1}}};
    end else if (r < R_MIN) begin
      return {1'b1, {(W-1){1'b0}}};
    end else begin
      return r[W-1:0];
    end
  endfunction

  // Credits: inflight counts pipe plus FIFO, so a full count means every FIFO slot is spoken for.
  // Derived from the register only; a pop frees its credit on the following cycle.
  assign in_stall = (inflight >= CNT_W'(FIFO_DEPTH));
  assign accept   = in_valid & ~in_stall;
  assign pop      = out_valid & ~out_stall;

  always_comb begin
    in_stg        = '0;
    in_stg.hit    = in_hit;
    in_stg.ray_id = in_rayID;
    in_stg.tri_id = in_triID;
    in_stg.org    = in_org;
    for (int a = 0; a < 3; a++) begin
      in_stg.prod[a*2*W +: 2*W] = mul_ax(in_t, in_dir[a*W +: W]);
    end
  end

  // Valid bits shift unconditionally; bubbles travel as zeros.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_vld <= '0;
    end else begin
      stg_vld[0] <= accept;
      for (int i = 1; i < MATH_LAT; i++) begin
        stg_vld[i] <= stg_vld[i-1];
      end
    end
  end

  // Data registers only load behind a valid so idle stages do not toggle.
  always_ff @(posedge clk) begin
    if (accept) begin
      stg_dat[0] <= in_stg;
    end
    for (int i = 1; i < MATH_LAT; i++) begin
      if (stg_vld[i-1]) begin
        stg_dat[i] <= stg_dat[i-1];
      end
    end
  end

  assign last_stg = stg_dat[MATH_LAT-1];

  always_comb begin
    wr_res        = '0;
    wr_res.ray_id = last_stg.ray_id;
    wr_res.tri_id = last_stg.tri_id;
    wr_res.hit    = last_stg.hit;
    for (int a = 0; a < 3; a++) begin
      wr_res.pos[a*W +: W] = last_stg.hit ?
          finish_ax(last_stg.prod[a*2*W +: 2*W], last_stg.org[a*W +: W]) : '0;
    end
  end

  // The last stage writes unconditionally; the credit count rules out overflow.
  pcalc_fifo #(
    .WIDTH ($bits(res_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .wr_vld (stg_vld[MATH_LAT-1]),
    .wr_dat (wr_res),
    .rd_vld (fifo_vld),
    .rd_rdy (~out_stall),
    .rd_dat (rd_res)
  );

  assign out_valid = fifo_vld;
  assign out_rayID = rd_res.ray_id;
  assign out_triID = rd_res.tri_id;
  assign out_hit   = rd_res.hit;
  assign out_pos   = rd_res.pos;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_pcalc_unit_param.sv
module tb_pcalc_unit_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_rayID = '0;
  logic [15:0] in_triID = '0;
  logic        in_hit = 1'b0;
  logic [15:0] in_t = '0;
  logic [47:0] in_org = '0;
  logic [47:0] in_dir = '0;
  logic        out_stall = 1'b0;

  logic        w_in_stall, s_in_stall;
  logic        w_out_valid, s_out_valid;
  logic [7:0]  w_out_rayID, s_out_rayID;
  logic [15:0] w_out_triID, s_out_triID;
  logic        w_out_hit, s_out_hit;
  logic [47:0] w_out_pos, s_out_pos;
  logic [3:0]  w_inflight, s_inflight;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcalc_unit_param #(.W(16), .FRAC(8), .ID_W(8), .TRI_W(16), .MATH_LAT(4),
                     .FIFO_DEPTH(8), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_stall(w_in_stall),
    .in_rayID(in_rayID), .in_triID(in_triID), .in_hit(in_hit), .in_t(in_t),
    .in_org(in_org), .in_dir(in_dir), .out_valid(w_out_valid), .out_stall(out_stall),
    .out_rayID(w_out_rayID), .out_triID(w_out_triID), .out_hit(w_out_hit),
    .out_pos(w_out_pos), .inflight(w_inflight)
  );

  pcalc_unit_param #(.W(16), .FRAC(8), .ID_W(8), .TRI_W(16), .MATH_LAT(4),
                     .FIFO_DEPTH(8), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_stall(s_in_stall),
    .in_rayID(in_rayID), .in_triID(in_triID), .in_hit(in_hit), .in_t(in_t),
    .in_org(in_org), .in_dir(in_dir), .out_valid(s_out_valid), .out_stall(out_stall),
    .out_rayID(s_out_rayID), .out_triID(s_out_triID), .out_hit(s_out_hit),
    .out_pos(s_out_pos), .inflight(s_inflight)
  );

  task automatic drive_entry(input logic [7:0] rid, input logic [15:0] tid, input logic hit,
                             input logic [15:0] t, input logic [47:0] org, input logic [47:0] dir);
    in_valid = 1'b1;
    in_rayID = rid;
    in_triID = tid;
    in_hit   = hit;
    in_t     = t;
    in_org   = org;
    in_dir   = dir;
  endtask

  task automatic clear_in();
    in_valid = 1'b0;
    in_hit   = 1'b0;
    in_rayID = '0;
    in_triID = '0;
    in_t     = '0;
    in_org   = '0;
    in_dir   = '0;
  endtask

  task automatic pop_one();
    out_stall = 1'b0;
    @(negedge clk);
    out_stall = 1'b1;
  endtask

  task automatic wait_head(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (w_out_valid) begin
        seen = 1'b1;
        return;
      end
      @(negedge clk);
    end
    seen = w_out_valid;
  endtask

  task automatic test_reset();
    clear_in();
    out_stall = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({w_out_valid, w_in_stall, w_inflight, w_out_rayID, w_out_triID, w_out_hit, w_out_pos} !== '0) begin
      errors++;
      $display("FAIL reset_wrap: valid=%0b stall=%0b inflight=%0d rid=%h tid=%h hit=%0b pos=%h, expected all 0",
               w_out_valid, w_in_stall, w_inflight, w_out_rayID, w_out_triID, w_out_hit, w_out_pos);
    end
    checks++;
    if ({s_out_valid, s_in_stall, s_inflight, s_out_rayID, s_out_triID, s_out_hit, s_out_pos} !== '0) begin
      errors++;
      $display("FAIL reset_sat: valid=%0b stall=%0b inflight=%0d pos=%h, expected all 0",
               s_out_valid, s_in_stall, s_inflight, s_out_pos);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    out_stall = 1'b0;
    drive_entry(8'd5, 16'd9, 1'b1, 16'h0200, {16'h0000, 16'h0000, 16'h0100},
                {16'h0080, 16'hFF00, 16'h0100});
    @(negedge clk);
    clear_in();
    checks++;
    if (w_inflight !== 4'd1) begin
      errors++;
      $display("FAIL basic_inflight: got %0d expected 1", w_inflight);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (w_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: out_valid=%0b after 4 edges, expected 0", w_out_valid);
    end
    @(negedge clk);
    checks++;
    if ({w_out_valid, w_out_rayID, w_out_triID, w_out_hit, w_out_pos} !==
        {1'b1, 8'd5, 16'd9, 1'b1, 48'h0100_FE00_0300}) begin
      errors++;
      $display("FAIL basic_data: valid=%0b rid=%0d tid=%0d hit=%0b pos=%h, expected 1/5/9/1/0100fe000300",
               w_out_valid, w_out_rayID, w_out_triID, w_out_hit, w_out_pos);
    end
    checks++;
    if (s_out_pos !== 48'h0100_FE00_0300) begin
      errors++;
      $display("FAIL basic_sat_pos: got %h expected 0100fe000300", s_out_pos);
    end
    @(negedge clk);
    checks++;
    if ({w_out_valid, w_inflight} !== 5'd0) begin
      errors++;
      $display("FAIL basic_drain: valid=%0b inflight=%0d, expected 0/0", w_out_valid, w_inflight);
    end
  endtask

  task automatic test_sat();
    logic [7:0]  e_rid [3];
    logic [47:0] e_w   [3];
    logic [47:0] e_s   [3];
    bit seen;
    e_rid[0] = 8'd1; e_w[0] = 48'h0000_0000_7100; e_s[0] = 48'h0000_0000_7FFF;
    e_rid[1] = 8'd2; e_w[1] = 48'h0000_0000_FF00; e_s[1] = 48'h0000_0000_8000;
    e_rid[2] = 8'd3; e_w[2] = 48'h0000_0000_FFFF; e_s[2] = 48'h0000_0000_FFFF;
    out_stall = 1'b1;
    drive_entry(8'd1, 16'd11, 1'b1, 16'h7F00, 48'h0000_0000_7000, 48'h0000_0000_7F00);
    @(negedge clk);
    drive_entry(8'd2, 16'd12, 1'b1, 16'h7F00, 48'h0, 48'h0000_0000_8100);
    @(negedge clk);
    drive_entry(8'd3, 16'd13, 1'b1, 16'h0001, 48'h0, 48'h0000_0001_FFFF);
    @(negedge clk);
    clear_in();
    wait_head(20, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL sat_timeout: out_valid never rose, expected 1");
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({w_out_valid, w_out_rayID, w_out_pos} !== {1'b1, e_rid[i], e_w[i]}) begin
        errors++;
        $display("FAIL sat_wrap_%0d: valid=%0b rid=%0d pos=%h, expected 1/%0d/%h",
                 i, w_out_valid, w_out_rayID, w_out_pos, e_rid[i], e_w[i]);
      end
      checks++;
      if ({s_out_valid, s_out_rayID, s_out_pos} !== {1'b1, e_rid[i], e_s[i]}) begin
        errors++;
        $display("FAIL sat_clamp_%0d: valid=%0b rid=%0d pos=%h, expected 1/%0d/%h",
                 i, s_out_valid, s_out_rayID, s_out_pos, e_rid[i], e_s[i]);
      end
      pop_one();
    end
    out_stall = 1'b0;
  endtask

  task automatic test_miss();
    bit seen;
    out_stall = 1'b1;
    drive_entry(8'd7, 16'hBEEF, 1'b0, 16'h0200, 48'h0000_0000_0100, 48'h0000_0000_0100);
    @(negedge clk);
    clear_in();
    wait_head(20, seen);
    checks++;
    if ({seen, w_out_rayID, w_out_triID, w_out_hit, w_out_pos} !== {1'b1, 8'd7, 16'hBEEF, 1'b0, 48'h0}) begin
      errors++;
      $display("FAIL miss_wrap: seen=%0b rid=%0d tid=%h hit=%0b pos=%h, expected 1/7/beef/0/0",
               seen, w_out_rayID, w_out_triID, w_out_hit, w_out_pos);
    end
    checks++;
    if ({s_out_rayID, s_out_triID, s_out_hit, s_out_pos} !== {8'd7, 16'hBEEF, 1'b0, 48'h0}) begin
      errors++;
      $display("FAIL miss_sat: rid=%0d tid=%h hit=%0b pos=%h, expected 7/beef/0/0",
               s_out_rayID, s_out_triID, s_out_hit, s_out_pos);
    end
    pop_one();
    out_stall = 1'b0;
  endtask

  task automatic test_burst_order();
    int sent = 0;
    int got = 0;
    logic        e_hit;
    logic [47:0] e_pos;
    out_stall = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (sent < 20) begin
        drive_entry(8'(sent + 16), 16'(sent * 7), (sent % 3) != 0, 16'h0100, 48'h0000_0000_1000,
                    {16'(3 * sent), 16'(0 - sent), 16'(sent)});
        sent++;
      end else begin
        clear_in();
      end
      @(negedge clk);
      if (w_out_valid) begin
        e_hit = (got % 3) != 0;
        e_pos = e_hit ? {16'(3 * got), 16'(0 - got), 16'(32'h1000 + got)} : 48'h0;
        checks++;
        if ({w_out_rayID, w_out_triID, w_out_hit, w_out_pos} !== {8'(got + 16), 16'(got * 7), e_hit, e_pos}) begin
          errors++;
          $display("FAIL burst_%0d: rid=%0d tid=%0d hit=%0b pos=%h, expected %0d/%0d/%0b/%h",
                   got, w_out_rayID, w_out_triID, w_out_hit, w_out_pos, got + 16, got * 7, e_hit, e_pos);
        end
        checks++;
        if (s_out_pos !== e_pos) begin
          errors++;
          $display("FAIL burst_sat_%0d: pos=%h expected %h", got, s_out_pos, e_pos);
        end
        got++;
      end
    end
    checks++;
    if (got != 20) begin
      errors++;
      $display("FAIL burst_count: got %0d outputs, expected 20", got);
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    int accepts = 0;
    int idx = 2;
    bit acc;
    out_stall = 1'b1;
    for (int c = 0; c < 14; c++) begin
      drive_entry(8'(k + 64), 16'(k), 1'b1, 16'h0100, 48'h0, {32'h0, 16'(k)});
      acc = !w_in_stall;
      @(negedge clk);
      if (acc) begin
        accepts++;
        k++;
      end
    end
    checks++;
    if (accepts != 8) begin
      errors++;
      $display("FAIL bp_accepts: got %0d expected 8", accepts);
    end
    checks++;
    if ({w_in_stall, w_inflight, s_inflight} !== {1'b1, 4'd8, 4'd8}) begin
      errors++;
      $display("FAIL bp_full: stall=%0b inflight=%0d/%0d, expected 1/8/8", w_in_stall, w_inflight, s_inflight);
    end
    checks++;
    if ({w_out_valid, w_out_rayID} !== {1'b1, 8'd64}) begin
      errors++;
      $display("FAIL bp_head0: valid=%0b rid=%0d, expected 1/64", w_out_valid, w_out_rayID);
    end
    // single pop while upstream still offers entry k
    pop_one();
    checks++;
    if ({w_in_stall, w_inflight} !== {1'b0, 4'd7}) begin
      errors++;
      $display("FAIL bp_release: stall=%0b inflight=%0d, expected 0/7", w_in_stall, w_inflight);
    end
    checks++;
    if (w_out_rayID !== 8'd65) begin
      errors++;
      $display("FAIL bp_head1: rid=%0d expected 65", w_out_rayID);
    end
    // accept and pop in the same cycle
    out_stall = 1'b0;
    @(negedge clk);
    k++;
    clear_in();
    out_stall = 1'b1;
    checks++;
    if (w_inflight !== 4'd7) begin
      errors++;
      $display("FAIL bp_acc_pop: inflight=%0d expected 7", w_inflight);
    end
    out_stall = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (w_out_valid) begin
        checks++;
        if ({w_out_rayID, w_out_pos} !== {8'(idx + 64), 32'h0, 16'(idx)}) begin
          errors++;
          $display("FAIL bp_drain_%0d: rid=%0d pos=%h, expected %0d/%h", idx, w_out_rayID, w_out_pos,
                   idx + 64, {32'h0, 16'(idx)});
        end
        idx++;
      end
      @(negedge clk);
    end
    checks++;
    if ({idx, w_inflight} !== {32'd9, 4'd0}) begin
      errors++;
      $display("FAIL bp_drain_count: last idx=%0d inflight=%0d, expected 9/0", idx, w_inflight);
    end
  endtask

  task automatic test_full_rate();
    int sent = 0;
    int got = 0;
    int first = -1;
    int gaps = 0;
    int stalls = 0;
    out_stall = 1'b0;
    for (int edge_n = 1; edge_n <= 130; edge_n++) begin
      if (sent < 100) begin
        if (w_in_stall) stalls++;
        drive_entry(8'(sent), 16'(sent + 1000), 1'b1, 16'h0100, 48'h0, {32'h0, 16'(sent)});
        sent++;
      end else begin
        clear_in();
      end
      @(negedge clk);
      if (w_out_valid) begin
        if (first < 0) first = edge_n;
        checks++;
        if ({w_out_rayID, w_out_triID, w_out_pos} !== {8'(got), 16'(got + 1000), 32'h0, 16'(got)}) begin
          errors++;
          $display("FAIL rate_data_%0d: rid=%0d tid=%0d pos=%h", got, w_out_rayID, w_out_triID, w_out_pos);
        end
        got++;
      end else if (first >= 0 && got < 100) begin
        gaps++;
      end
    end
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL rate_stall: in_stall seen %0d cycles, expected 0", stalls);
    end
    checks++;
    if (first != 5) begin
      errors++;
      $display("FAIL rate_first: first out_valid after edge %0d, expected 5", first);
    end
    checks++;
    if (gaps != 0 || got != 100) begin
      errors++;
      $display("FAIL rate_continuity: gaps=%0d outputs=%0d, expected 0/100", gaps, got);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    out_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_entry(8'(8'hA0 + i), 16'(i), 1'b1, 16'h0100, 48'h0, {32'h0, 16'(i + 1)});
      @(negedge clk);
    end
    clear_in();
    checks++;
    if ({w_out_valid, w_inflight} !== {1'b1, 4'd6}) begin
      errors++;
      $display("FAIL areset_pre: valid=%0b inflight=%0d, expected 1/6", w_out_valid, w_inflight);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({w_out_valid, w_inflight, w_in_stall, w_out_pos, s_out_valid, s_inflight} !== '0) begin
      errors++;
      $display("FAIL areset_now: valid=%0b inflight=%0d stall=%0b pos=%h sat_valid=%0b sat_inflight=%0d, expected all 0",
               w_out_valid, w_inflight, w_in_stall, w_out_pos, s_out_valid, s_inflight);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    out_stall = 1'b0;
    drive_entry(8'h55, 16'h1234, 1'b1, 16'h0200, 48'h0000_0000_0100, 48'h0000_0000_0100);
    @(negedge clk);
    clear_in();
    wait_head(20, seen);
    checks++;
    if ({seen, w_out_rayID, w_out_triID, w_out_hit, w_out_pos} !== {1'b1, 8'h55, 16'h1234, 1'b1, 48'h0000_0000_0300}) begin
      errors++;
      $display("FAIL areset_after: seen=%0b rid=%h tid=%h hit=%0b pos=%h, expected 1/55/1234/1/000000000300",
               seen, w_out_rayID, w_out_triID, w_out_hit, w_out_pos);
    end
    @(negedge clk);
    checks++;
    if ({w_out_valid, w_inflight} !== 5'd0) begin
      errors++;
      $display("FAIL areset_empty: valid=%0b inflight=%0d, expected 0/0", w_out_valid, w_inflight);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_sat();
    test_miss();
    test_burst_order();
    test_backpressure();
    test_full_rate();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
